// File: rtl/e203_exu_lpipe_tracker.sv
// In-order tracker for long-pipe (LSU/MULDIV) instructions: tags dispatches, retires in order,
// and flags RAW/WAW hazards against dispatch. Define E203_LPIPE_TRACK_PC_EN to store per-entry PCs.
module e203_exu_lpipe_tracker #(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             dis_ena,
  output logic             dis_ready,
  output logic [PTR_W-1:0] dis_ptr,

  input  logic             disp_i_rs1en,
  input  logic             disp_i_rs2en,
  input  logic             disp_i_rdwen,
  input  logic [4:0]       disp_i_rs1idx,
  input  logic [4:0]       disp_i_rs2idx,
  input  logic [4:0]       disp_i_rdidx,
  input  logic [31:0]      disp_i_pc,

  input  logic             ret_ena,
  output logic [PTR_W-1:0] ret_ptr,
  output logic [4:0]       ret_rdidx,
  output logic             ret_rdwen,
  output logic [31:0]      ret_pc,

  output logic             oitfrd_match_disprs1,
  output logic             oitfrd_match_disprs2,
  output logic             oitfrd_match_disprd,
  output logic             oitf_empty
);

  // Pointers carry one extra wrap bit; DEPTH is a power of two so plain +1 toggles it at DEPTH-1 -> 0.
  logic [PTR_W:0]   alc_ptr_r;
  logic [PTR_W:0]   ret_ptr_r;
  logic [PTR_W-1:0] alc_idx;
  logic [PTR_W-1:0] ret_idx;
  logic             full;
  logic             empty;
  logic             alc_fire;
  logic             ret_fire;

  logic [DEPTH-1:0] vld_r;
  logic [DEPTH-1:0] rdwen_r;
  logic [4:0]       rdidx_r [DEPTH];

  assign alc_idx = alc_ptr_r[PTR_W-1:0];
  assign ret_idx = ret_ptr_r[PTR_W-1:0];

  assign empty = (alc_ptr_r == ret_ptr_r);
  assign full  = (alc_idx == ret_idx) & (alc_ptr_r[PTR_W] != ret_ptr_r[PTR_W]);

  // Both fire conditions look only at pre-edge occupancy, so full drops the allocate and empty drops the retire.
  assign alc_fire = dis_ena & ~full;
  assign ret_fire = ret_ena & ~empty;

  assign dis_ready  = ~full;
  assign oitf_empty = empty;
  assign dis_ptr    = alc_idx;
  assign ret_ptr    = ret_idx;

  // NOTE: sequential state is written only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alc_ptr_r <= '0;
      ret_ptr_r <= '0;
    end else begin
      if (alc_fire) alc_ptr_r <= alc_ptr_r + {{PTR_W{1'b0}}, 1'b1};
      if (ret_fire) ret_ptr_r <= ret_ptr_r + {{PTR_W{1'b0}}, 1'b1};
    end
  end

  // NOTE: the entry array is reset as well, because the oldest entry's fields are visible on ret_* straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r   <= '0;
      rdwen_r <= '0;
      for (int i = 0; i < DEPTH; i++) rdidx_r[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ret_fire && (ret_idx == PTR_W'(i))) vld_r[i] <= 1'b0;
        if (alc_fire && (alc_idx == PTR_W'(i))) begin
          vld_r[i]   <= 1'b1;
          rdwen_r[i] <= disp_i_rdwen;
          rdidx_r[i] <= disp_i_rdidx;
        end
      end
    end
  end

  assign ret_rdidx = rdidx_r[ret_idx];
  assign ret_rdwen = rdwen_r[ret_idx];

`ifdef E203_LPIPE_TRACK_PC_EN
  logic [31:0] pc_r [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pc_r[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alc_fire && (alc_idx == PTR_W'(i))) pc_r[i] <= disp_i_pc;
      end
    end
  end

  assign ret_pc = pc_r[ret_idx];
`else
  logic unused_pc;

  assign unused_pc = ^disp_i_pc;
  assign ret_pc    = 32'h0;
`endif

  logic hit_rs1;
  logic hit_rs2;
  logic hit_rd;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    hit_rs1 = 1'b0;
    hit_rs2 = 1'b0;
    hit_rd  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_r[i] && rdwen_r[i]) begin
        if (rdidx_r[i] == disp_i_rs1idx) hit_rs1 = 1'b1;
        if (rdidx_r[i] == disp_i_rs2idx) hit_rs2 = 1'b1;
        if (rdidx_r[i] == disp_i_rdidx)  hit_rd  = 1'b1;
      end
    end
  end

  assign oitfrd_match_disprs1 = hit_rs1 & disp_i_rs1en;
  assign oitfrd_match_disprs2 = hit_rs2 & disp_i_rs2en;
  assign oitfrd_match_disprd  = hit_rd  & disp_i_rdwen;

endmodule

// File: tb/tb_e203_exu_lpipe_tracker.sv
// Directed bench for e203_exu_lpipe_tracker: a queue of expected entries is filled on allocation
// and drained/compared on retire; hazard, wrap, collision and reset cases are checked directly.
module tb_e203_exu_lpipe_tracker;
  localparam int DEPTH = 2;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clk;
  logic             rst_n;
  logic             dis_ena;
  logic             dis_ready;
  logic [PTR_W-1:0] dis_ptr;
  logic             disp_i_rs1en;
  logic             disp_i_rs2en;
  logic             disp_i_rdwen;
  logic [4:0]       disp_i_rs1idx;
  logic [4:0]       disp_i_rs2idx;
  logic [4:0]       disp_i_rdidx;
  logic [31:0]      disp_i_pc;
  logic             ret_ena;
  logic [PTR_W-1:0] ret_ptr;
  logic [4:0]       ret_rdidx;
  logic             ret_rdwen;
  logic [31:0]      ret_pc;
  logic             oitfrd_match_disprs1;
  logic             oitfrd_match_disprs2;
  logic             oitfrd_match_disprd;
  logic             oitf_empty;

  e203_exu_lpipe_tracker #(.DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .dis_ena              (dis_ena),
    .dis_ready            (dis_ready),
    .dis_ptr              (dis_ptr),
    .disp_i_rs1en         (disp_i_rs1en),
    .disp_i_rs2en         (disp_i_rs2en),
    .disp_i_rdwen         (disp_i_rdwen),
    .disp_i_rs1idx        (disp_i_rs1idx),
    .disp_i_rs2idx        (disp_i_rs2idx),
    .disp_i_rdidx         (disp_i_rdidx),
    .disp_i_pc            (disp_i_pc),
    .ret_ena              (ret_ena),
    .ret_ptr              (ret_ptr),
    .ret_rdidx            (ret_rdidx),
    .ret_rdwen            (ret_rdwen),
    .ret_pc               (ret_pc),
    .oitfrd_match_disprs1 (oitfrd_match_disprs1),
    .oitfrd_match_disprs2 (oitfrd_match_disprs2),
    .oitfrd_match_disprd  (oitfrd_match_disprd),
    .oitf_empty           (oitf_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [PTR_W-1:0] ptr;
    logic [4:0]       rdidx;
    logic             rdwen;
    logic [31:0]      pc;
  } entry_t;

  entry_t sb[$];
  int     alc_model;
  int     errors;
  int     checks;

  function automatic logic [31:0] exp_pc(input logic [31:0] pc);
`ifdef E203_LPIPE_TRACK_PC_EN
    return pc;
`else
    return 32'h0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of dispatch/retire traffic; called at posedge+1, returns at the next posedge+1.
  task automatic cycle(input logic dis, input logic ret, input logic [4:0] rd,
                       input logic rdwen, input logic [31:0] pc);
    logic   a_ok;
    logic   r_ok;
    entry_t e;
    dis_ena      = dis;
    ret_ena      = ret;
    disp_i_rdidx = rd;
    disp_i_rdwen = rdwen;
    disp_i_pc    = pc;
    #1;
    check("dis_ready", dis_ready, sb.size() < DEPTH);
    check("oitf_empty", oitf_empty, sb.size() == 0);
    a_ok = dis && (sb.size() < DEPTH);
    r_ok = ret && (sb.size() > 0);
    if (r_ok) begin
      e = sb.pop_front();
      check("ret_ptr", ret_ptr, e.ptr);
      check("ret_rdidx", ret_rdidx, e.rdidx);
      check("ret_rdwen", ret_rdwen, e.rdwen);
      check("ret_pc", ret_pc, exp_pc(e.pc));
    end
    if (a_ok) begin
      check("dis_ptr", dis_ptr, alc_model[PTR_W-1:0]);
      e.ptr = alc_model[PTR_W-1:0];
      e.rdidx = rd;
      e.rdwen = rdwen;
      e.pc = pc;
      sb.push_back(e);
      alc_model = (alc_model + 1) % DEPTH;
    end
    @(posedge clk);
    #1;
    dis_ena = 1'b0;
    ret_ena = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    alc_model = 0;
    rst_n = 1'b0;
    dis_ena = 1'b0;
    ret_ena = 1'b0;
    disp_i_rs1en = 1'b1;
    disp_i_rs2en = 1'b1;
    disp_i_rdwen = 1'b1;
    disp_i_rs1idx = 5'd0;
    disp_i_rs2idx = 5'd0;
    disp_i_rdidx = 5'd0;
    disp_i_pc = 32'h0;

    #2;
    check("rst_dis_ready", dis_ready, 1);
    check("rst_oitf_empty", oitf_empty, 1);
    check("rst_dis_ptr", dis_ptr, 0);
    check("rst_ret_ptr", ret_ptr, 0);
    check("rst_ret_rdidx", ret_rdidx, 0);
    check("rst_ret_rdwen", ret_rdwen, 0);
    check("rst_ret_pc", ret_pc, 0);
    check("rst_match_rs1", oitfrd_match_disprs1, 0);
    check("rst_match_rs2", oitfrd_match_disprs2, 0);
    check("rst_match_rd", oitfrd_match_disprd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill, then probe hazards against the two live entries.
    cycle(1, 0, 5'd5, 1, 32'h8000_0104);
    cycle(1, 0, 5'd7, 1, 32'h8000_0108);
    check("full_dis_ready", dis_ready, 0);
    check("full_oitf_empty", oitf_empty, 0);
    check("oldest_ret_pc", ret_pc, exp_pc(32'h8000_0104));
    disp_i_rs1idx = 5'd7; disp_i_rs1en = 1'b1;
    disp_i_rs2idx = 5'd3; disp_i_rs2en = 1'b1;
    disp_i_rdidx  = 5'd9; disp_i_rdwen = 1'b1;
    #1;
    check("raw_rs1_hit", oitfrd_match_disprs1, 1);
    check("raw_rs2_miss", oitfrd_match_disprs2, 0);
    check("waw_rd_miss", oitfrd_match_disprd, 0);
    disp_i_rs1en = 1'b0;
    #1;
    check("raw_rs1_masked", oitfrd_match_disprs1, 0);
    disp_i_rdidx = 5'd5;
    #1;
    check("waw_rd_hit", oitfrd_match_disprd, 1);
    disp_i_rdwen = 1'b0;
    #1;
    check("waw_rd_masked", oitfrd_match_disprd, 0);

    // Dispatch while full is dropped.
    cycle(1, 0, 5'd11, 1, 32'h0000_0bad);
    check("full_drop_dis_ptr", dis_ptr, 0);
    check("full_drop_ret_ptr", ret_ptr, 0);

    // In-order retire, then an ignored retire on empty.
    cycle(0, 1, 5'd0, 0, 32'h0);
    cycle(0, 1, 5'd0, 0, 32'h0);
    check("drained_empty", oitf_empty, 1);
    cycle(0, 1, 5'd0, 0, 32'h0);
    check("empty_ret_ptr", ret_ptr, 0);
    check("empty_ret_rdidx_kept", ret_rdidx, 5'd5);
    check("empty_dis_ptr", dis_ptr, 0);

    // Wrap: dis_ptr walks 0,1,0,1.
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 5'(i + 12), 1, 32'h1000 + 32'(i));
      cycle(0, 1, 5'd0, 0, 32'h0);
    end

    // Simultaneous events with one held, full, and empty.
    cycle(1, 0, 5'd3, 1, 32'h2000);
    cycle(1, 1, 5'd4, 1, 32'h2004);
    check("both_one_empty", oitf_empty, 0);
    check("both_one_ready", dis_ready, 1);
    cycle(1, 0, 5'd6, 0, 32'h2008);
    check("both_full_pre", dis_ready, 0);
    cycle(1, 1, 5'd8, 1, 32'h200c);
    check("both_full_ready", dis_ready, 1);
    cycle(0, 1, 5'd0, 0, 32'h0);
    cycle(1, 1, 5'd10, 1, 32'h2010);
    check("both_empty_alloc", oitf_empty, 0);
    cycle(0, 1, 5'd0, 0, 32'h0);

    // rd-write-enable masking on the match path.
    cycle(1, 0, 5'd9, 0, 32'h3000);
    disp_i_rs2idx = 5'd9; disp_i_rs2en = 1'b1;
    #1;
    check("rdwen0_rs2_nomatch", oitfrd_match_disprs2, 0);
    check("rdwen0_ret_rdwen", ret_rdwen, 0);
    cycle(1, 0, 5'd9, 1, 32'h3004);
    disp_i_rs2idx = 5'd9; disp_i_rs2en = 1'b1;
    #1;
    check("rdwen1_rs2_match", oitfrd_match_disprs2, 1);

    // Asynchronous reset with two entries held.
    disp_i_rs1idx = 5'd9; disp_i_rs1en = 1'b1;
    disp_i_rdidx  = 5'd9; disp_i_rdwen = 1'b1;
    #1;
    check("pre_rst_match_rs1", oitfrd_match_disprs1, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_oitf_empty", oitf_empty, 1);
    check("mid_rst_dis_ready", dis_ready, 1);
    check("mid_rst_dis_ptr", dis_ptr, 0);
    check("mid_rst_ret_ptr", ret_ptr, 0);
    check("mid_rst_match_rs1", oitfrd_match_disprs1, 0);
    check("mid_rst_match_rs2", oitfrd_match_disprs2, 0);
    check("mid_rst_match_rd", oitfrd_match_disprd, 0);
    check("mid_rst_ret_pc", ret_pc, 0);
    sb.delete();
    alc_model = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1, 0, 5'd2, 1, 32'h4000);
    cycle(0, 1, 5'd0, 0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
